// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver: shadowed digit data, hex decode,
// per-digit enable/dp/blink, programmable scan rate and anti-ghosting blank window.
module seg_scan_display #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter int BLINK_FRAMES   = 64,
    parameter int DS_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   ds,
    output logic [7:0]              seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Idle levels of the pins after polarity; XOR with these applies polarity.
    localparam logic [NUM_DIGITS-1:0] DS_OFF  = (DS_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic [NUM_DIGITS-1:0]   shadow_blink;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    phase;
    logic                    tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_en     <= '0;
            shadow_blink  <= '0;
        end else if (load) begin
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
            shadow_en     <= en_in;
            shadow_blink  <= blink_in;
        end
    end

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    generate
        if (BLINK_FRAMES > 0) begin : g_blink
            localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
            localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
            logic [FRM_W-1:0] frm;

            // One frame ends on the tick out of the last digit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    frm   <= '0;
                    phase <= 1'b0;
                end else if (tick && (idx == IDX_LAST)) begin
                    if (frm == FRM_LAST) begin
                        frm   <= '0;
                        phase <= ~phase;
                    end else begin
                        frm <= frm + 1'b1;
                    end
                end
            end
        end else begin : g_no_blink
            assign phase = 1'b0;
        end
    endgenerate

    // ---- stage p0: select current digit's shadow data, decide blanking ----
    logic [3:0]            digit_p0;
    logic                  dp_p0;
    logic                  en_p0;
    logic                  blink_p0;
    logic                  blank_p0;
    logic [NUM_DIGITS-1:0] ds_p0;
    logic [7:0]            seg_p0;

    always_comb begin
        digit_p0 = '0;
        dp_p0    = 1'b0;
        en_p0    = 1'b0;
        blink_p0 = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                digit_p0 = shadow_digits[4*k +: 4];
                dp_p0    = shadow_dp[k];
                en_p0    = shadow_en[k];
                blink_p0 = shadow_blink[k];
            end
        end
        blank_p0 = (int'(cnt) < BLANK_CYCLES) || !en_p0 || (phase && blink_p0);
        ds_p0    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        seg_p0   = {dp_p0, hex_decode(digit_p0)};
    end

    // ---- stage p1: registered pin drive with polarity applied ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds  <= DS_OFF;
            seg <= SEG_OFF;
        end else if (blank_p0) begin
            ds  <= DS_OFF;
            seg <= SEG_OFF;
        end else begin
            ds  <= ds_p0 ^ DS_OFF;
            seg <= seg_p0 ^ SEG_OFF;
        end
    end

    a_ds_onehot : assert property (@(posedge clk) disable iff (rst) $countones(ds ^ DS_OFF) <= 1);

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed scenarios plus random loads/resets,
// every cycle compared with a time-indexed reference of the scan schedule.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    en_in = '0;
    logic [3:0]    blink_in = '0;
    logic [3:0]    ds;
    logic [7:0]    seg;

    int n_vec = 0;
    int n_err = 0;
    int t = 0;
    int last_t = 0;

    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_en = '0;
    logic [3:0]  m_blk = '0;
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_display #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
        .DS_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .en_in(en_in),
        .blink_in(blink_in), .load(load), .ds(ds), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    // Expected pins for the cycle that is tt cycles after reset release.
    function automatic void model(input int tt, output logic [3:0] eds, output logic [7:0] eseg);
        int  slot, c, k, frame;
        bit  ph, off;
        slot  = tt / SD;
        c     = tt % SD;
        k     = slot % ND;
        frame = slot / ND;
        ph    = (BF == 0) ? 1'b0 : (((frame / BF) % 2) == 1);
        off   = (c < BC) || !m_en[k] || (ph && m_blk[k]);
        if (off) begin
            eds  = 4'hF;
            eseg = 8'h00;
        end else begin
            eds  = ~(4'b0001 << k);
            eseg = {m_dp[k], hex_tab[m_dig[4*k +: 4]]};
        end
    endfunction

    task automatic cycle();
        logic [3:0] eds;
        logic [7:0] eseg;
        @(posedge clk);
        if (rst) begin
            eds = 4'hF; eseg = 8'h00;
            m_dig = '0; m_dp = '0; m_en = '0; m_blk = '0;
            t = 0;
        end else begin
            model(t, eds, eseg);
            if (load) begin
                m_dig = digits_in; m_dp = dp_in; m_en = en_in; m_blk = blink_in;
            end
            last_t = t;
            t++;
        end
        #1;
        chk("ds", ds, eds);
        chk("seg", seg, eseg);
        chk("ds_onehot", ($countones(~ds) <= 1), 1);
        @(negedge clk);
    endtask

    task automatic goto_pos(input int pos);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (((last_t % FRAME) != pos) && (n < 40));
        chk("goto", last_t % FRAME, pos);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                           input logic [3:0] bl);
        digits_in = d; dp_in = dp; en_in = en; blink_in = bl;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic do_reset();
        load = 1'b0;
        rst  = 1'b1;
        #1;
        chk("rst_async_ds", ds, 4'hF);
        chk("rst_async_seg", seg, 8'h00);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_ds", ds, 4'hF);
        chk("rst_seg", seg, 8'h00);
        rst = 1'b0;

        // Basic scan of 4321, all enabled
        do_load(16'h4321, 4'h0, 4'hF, 4'h0);
        goto_pos(0);  chk("scan_blank_ds", ds, 4'hF); chk("scan_blank_seg", seg, 8'h00);
        goto_pos(1);  chk("d0_ds", ds, 4'b1110); chk("d0_seg", seg, 8'h06);
        goto_pos(5);  chk("d1_ds", ds, 4'b1101); chk("d1_seg", seg, 8'h5B);
        goto_pos(9);  chk("d2_ds", ds, 4'b1011); chk("d2_seg", seg, 8'h4F);
        goto_pos(13); chk("d3_ds", ds, 4'b0111); chk("d3_seg", seg, 8'h66);
        goto_pos(1);  chk("wrap_d0_seg", seg, 8'h06);

        // Hex letters with decimal points on digits 0 and 2
        do_load(16'hFEDC, 4'b0101, 4'hF, 4'h0);
        goto_pos(1);  chk("C_dp", seg, 8'hB9);
        goto_pos(5);  chk("d", seg, 8'h5E);
        goto_pos(9);  chk("E_dp", seg, 8'hF9);
        goto_pos(13); chk("F", seg, 8'h71);

        // Digit 2 disabled
        do_load(16'hFEDC, 4'b0101, 4'b1011, 4'h0);
        for (int p = 8; p < 12; p++) begin
            goto_pos(p);
            chk("en_off_ds", ds, 4'hF);
            chk("en_off_seg", seg, 8'h00);
        end
        goto_pos(13); chk("en_d3_seg", seg, 8'h71);

        // Reset mid-slot at idx=2, cnt=2
        goto_pos(9);
        do_reset();
        for (int i = 0; i < SD; i++) begin
            cycle();
            chk("post_rst_ds", ds, 4'hF);
            chk("post_rst_seg", seg, 8'h00);
        end

        // Blink: frames 0-1 shown, 2-3 blanked, 4 shown
        do_reset();
        do_load(16'hFEDC, 4'b0101, 4'hF, 4'b0001);
        for (int f = 0; f < 5; f++) begin
            goto_pos(1);
            chk("blink_frame", last_t / FRAME, f);
            chk("blink_d0", seg, (f == 2 || f == 3) ? 8'h00 : 8'hB9);
            goto_pos(5);
            chk("blink_d1", seg, 8'h5E);
        end

        // Load on the same edge as the tick into digit 1
        do_load(16'h0021, 4'h0, 4'hF, 4'h0);
        goto_pos(2);
        digits_in = 16'h0085;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("lt_old_d0", seg, 8'h06);
        cycle();
        chk("lt_blank", seg, 8'h00);
        cycle();
        chk("lt_new_d1", seg, 8'h7F);
        chk("lt_new_d1_ds", ds, 4'b1101);

        // Random loads and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                load = ($urandom_range(0, 7) == 0);
                if (load) begin
                    digits_in = 16'($urandom);
                    dp_in     = 4'($urandom);
                    en_in     = 4'($urandom);
                    blink_in  = 4'($urandom);
                end
                cycle();
            end
        end
        load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
